// File: rtl/slave_step_counter.sv
// slave_step_counter: timed 4-bit slave state sequencer gated by the master code.
// Optional macro SLAVE_FAST_SIM_EN forces a divisor of 1 (one step per RUN cycle).
module slave_step_counter #(
    parameter logic [1:0] MY_ID       = 2'd1,
    parameter logic [3:0] START_STATE = 4'd0,
    parameter logic [3:0] END_STATE   = 4'd7,
    parameter bit         COUNT_UP    = 1'b1,
    parameter int unsigned TICK_DIV   = 100_000_000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [1:0] MASTER_CONTROL,
    output logic [3:0] STATE_OUT,
    output logic       ACTIVE,
    output logic       DONE
);

`ifdef SLAVE_FAST_SIM_EN
    localparam int unsigned DIV = 1;
`else
    localparam int unsigned DIV = TICK_DIV;
`endif
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        HOLD
    } state_t;

    state_t        state, state_n;
    logic [PW-1:0] pre, pre_n;
    logic [3:0]    cnt_n;
    logic [3:0]    step;
    logic          mine;

    assign mine = (MASTER_CONTROL == MY_ID);
    assign step = COUNT_UP ? STATE_OUT + 4'd1 : STATE_OUT - 4'd1;

    // Next-state, next count and prescaler; a zero master code always aborts
    always_comb begin
        state_n = state;
        cnt_n   = STATE_OUT;
        pre_n   = pre;
        if (MASTER_CONTROL == 2'd0) begin
            state_n = IDLE;
            cnt_n   = START_STATE;
            pre_n   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (mine) begin
                        pre_n   = '0;
                        state_n = (START_STATE == END_STATE) ? HOLD : RUN;
                    end
                end
                RUN, PAUSE: begin
                    if (mine) begin
                        state_n = RUN;
                        if (pre == LAST) begin
                            pre_n = '0;
                            cnt_n = step;
                            if (step == END_STATE)
                                state_n = HOLD;
                        end else begin
                            pre_n = pre + PW'(1);
                        end
                    end else begin
                        state_n = PAUSE;
                    end
                end
                HOLD: begin
                    cnt_n = END_STATE;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // State, count, prescaler and flag registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            STATE_OUT <= START_STATE;
            pre       <= '0;
            ACTIVE    <= 1'b0;
            DONE      <= 1'b0;
        end else begin
            state     <= state_n;
            STATE_OUT <= cnt_n;
            pre       <= pre_n;
            ACTIVE    <= (state_n == RUN);
            DONE      <= (state_n == HOLD);
        end
    end

endmodule

// File: doc/slave_step_counter.md
# slave_step_counter

Timed sequence generator that sits directly upstream of the master state machine and supplies one of its 4-bit slave state inputs. Each instance watches the 2-bit master control code and runs only while the master selects its ID. While running it steps a 4-bit state value up or down once per prescaler period, then parks and flags completion at a programmed end value. Two instances are used: an up-counter (0→7) and a down-counter (15→8).

## Interface
- MY_ID, 2'd1: master control code that enables this instance (must be non-zero).
- START_STATE, 4'd0: value loaded into STATE_OUT in IDLE.
- END_STATE, 4'd7: terminal value; reaching it ends the run.
- COUNT_UP, 1: 1 = increment per step, 0 = decrement per step.
- TICK_DIV, 100_000_000: clock cycles per step (≥1); one step per second at 100 MHz.
- CLK  input  1  system clock; all state changes on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- MASTER_CONTROL  input  2  current master state code.
- STATE_OUT  output  4  current slave state value, registered.
- ACTIVE  output  1  high while in RUN, registered.
- DONE  output  1  high while in HOLD, registered.

## Operation
- FSM states: IDLE, RUN, PAUSE, HOLD. Prescaler counter is $clog2(TICK_DIV) bits wide, minimum 1.
- Priority on each edge: RESET > MASTER_CONTROL==0 > per-state rules.
- RESET or MASTER_CONTROL==0: state←IDLE, STATE_OUT←START_STATE, prescaler←0, ACTIVE←0, DONE←0.
- IDLE: when MASTER_CONTROL==MY_ID → RUN, prescaler←0. If START_STATE==END_STATE → HOLD directly. Other codes: stay in IDLE.
- RUN: if prescaler==TICK_DIV-1 → prescaler←0 and STATE_OUT←STATE_OUT±1 (modulo 16). Otherwise prescaler←prescaler+1. If the new STATE_OUT equals END_STATE → HOLD on the same edge. If MASTER_CONTROL is non-zero and ≠MY_ID → PAUSE; STATE_OUT and prescaler freeze and no step occurs on that edge.
- PAUSE: hold all values; MASTER_CONTROL==MY_ID → RUN and counting resumes from the frozen prescaler value.
- HOLD: STATE_OUT stays at END_STATE and DONE=1 for any non-zero MASTER_CONTROL. Only a zero code or RESET leaves HOLD.
- Wrap-around: 4'hF+1=4'h0 and 4'h0-1=4'hF. Counting continues through the wrap until END_STATE is reached.

## Timing
- Reset values: STATE_OUT=START_STATE, ACTIVE=0, DONE=0, prescaler=0, state IDLE.
- ACTIVE rises on the edge that samples MASTER_CONTROL==MY_ID in IDLE.
- First STATE_OUT change comes exactly TICK_DIV edges after entering RUN. Later steps are every TICK_DIV edges while in RUN.
- DONE rises and ACTIVE falls on the same edge that STATE_OUT becomes END_STATE. Downstream therefore sees STATE_OUT==END_STATE and DONE together, with no intermediate cycle.
- Run length from enable to DONE = |steps| × TICK_DIV cycles, where |steps| counts modulo 16 in the configured direction.
- Cycles spent in PAUSE do not count toward the prescaler period.
- MASTER_CONTROL is used directly and is assumed synchronous to CLK (it comes from a register in the same domain).

## Configuration
- SLAVE_FAST_SIM_EN defined: the effective divisor is forced to 1, so STATE_OUT steps on every RUN cycle and the TICK_DIV parameter is ignored. Used for simulation benches.
- SLAVE_FAST_SIM_EN undefined: the TICK_DIV parameter is honoured as specified.

## Test plan
- Reset mid-run: instance MY_ID=1, START=0, END=7, up, TICK_DIV=4. Hold RESET 2 cycles → STATE_OUT=0, ACTIVE=0, DONE=0. Set MASTER_CONTROL=1 → STATE_OUT reads 1 at 4 edges after ACTIVE rises, 7 at 28 edges after, with DONE=1 and ACTIVE=0 on that edge. Assert RESET at STATE_OUT=3 → STATE_OUT=0 and state IDLE on the next edge.
- Down-counter: MY_ID=3, START=15, END=8, down, TICK_DIV=2, MASTER_CONTROL=3 → sequence 15,14,…,8 at 2-cycle spacing. DONE rises with STATE_OUT=8 after 14 edges in RUN.
- Pause: during the up run at STATE_OUT=3 with prescaler=2, set MASTER_CONTROL=2 for 10 cycles → STATE_OUT stays 3 and ACTIVE=0. Restore 1 → next step to 4 occurs 2 edges later.
- HOLD stickiness: after DONE, drive MASTER_CONTROL to 2, then 1, then 3 → STATE_OUT stays 7 and DONE=1. Drive 0 → STATE_OUT=0 and DONE=0 next edge.
- Wrap and degenerate cases: MY_ID=1, START=14, END=1, up, TICK_DIV=1 → sequence 14,15,0,1 with DONE on 1. START=END=5 → DONE=1 one edge after enable, with no step taken.
- Macro: compile with SLAVE_FAST_SIM_EN and TICK_DIV=100 → up run 0→7 completes in 7 edges after entering RUN.
